ucsbece154b_mem_arbiter: RTL and testbench
==========================================

Name: ucsbece154b_mem_arbiter

Overview:
- Two-master, one-slave read arbiter for the shared SDRAM model port (ucsbece154_imem-style ReadRequest/ReadAddress/DataIn/DataReady).
- Master I is the instruction cache miss port; master D is the data cache refill port, to be added next.
- Grants whole block bursts with round-robin fairness, routes the address/request of the granted master to memory, and steers DataReady beats back only to the owner.
- Sits in ucsbece154b_top between the caches and the SDRAM model.

Parameters:
WORDS_PER_BLOCK, 4, beats per burst; a grant is released after this many DataReady beats (>=1).
ADDR_W, 32, address width.
DATA_W, 32, data width.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
IReadRequest  input  1  master I request; held high with stable address until its last beat.
IReadAddress  input  ADDR_W  master I block address.
IDataIn  output  DATA_W  read data to master I.
IDataReady  output  1  beat valid to master I.
DReadRequest  input  1  master D request; same rules as I.
DReadAddress  input  ADDR_W  master D block address.
DDataIn  output  DATA_W  read data to master D.
DDataReady  output  1  beat valid to master D.
MemReadRequest  output  1  request to SDRAM.
MemReadAddress  output  ADDR_W  address to SDRAM.
MemDataIn  input  DATA_W  SDRAM read data.
MemDataReady  input  1  SDRAM beat valid.
GrantI  output  1  registered; master I owns memory.
GrantD  output  1  registered; master D owns memory.
Busy  output  1  GrantI | GrantD.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- States: IDLE, GNT_I, GNT_D. Registers: state, beat counter (clog2(WORDS_PER_BLOCK+1) bits), last_grant (I/D).
- Reset, and any cycle with reset high including mid-burst:
  - state=IDLE, count=0, last_grant=D, so I wins the first tie.
  - GrantI=GrantD=0, MemReadRequest=0, IDataReady=DDataReady=0.
  - In-flight beats are dropped.
- IDLE:
  - Only one of I or D requesting: move to that master's GNT state next edge.
  - Both requesting: grant the master that is not last_grant.
  - No request: stay.
  - In IDLE, MemReadRequest=0 and MemReadAddress=0.
- Arbitration latency: request sampled high at edge n gives Grant and MemReadRequest high during cycle n+1. Outputs come from registered state only, with no combinational request-to-MemReadRequest path.
- GNT_x:
  - MemReadRequest=1 and MemReadAddress=xReadAddress.
  - xDataIn=MemDataIn; xDataReady=MemDataReady.
  - The non-owner's DataReady is forced to 0. Both DataIn buses may carry MemDataIn.
  - Each MemDataReady increments count.
  - On the beat where count==WORDS_PER_BLOCK-1: next state=IDLE, count=0, last_grant=x. MemReadRequest drops in the following cycle.
- Mandatory one-cycle IDLE gap between bursts. Requesters drop their request in the cycle after their last beat; that cycle is IDLE.
- A request still high in IDLE is treated as a new request.
- Deassertion of xReadRequest while granted is illegal. The grant is held until the beat count completes; no abort.
- MemDataReady while IDLE: ignored, no output beat, count unchanged.
- The losing requester's request is never dropped by the arbiter. It is served right after the current burst, giving a bounded wait of one burst plus the gap.
- GrantI and GrantD are never both 1.

Test Plan:
- Solo I: IReadRequest=1, addr 0x100; memory returns 4 beats 0xA0..0xA3 -> GrantI and MemReadRequest high the cycle after the request. MemReadAddress=0x100. IDataReady pulses 4 times with matching data. DDataReady stays 0. Back to IDLE after beat 4.
- Tie from reset: I and D both request at the same edge -> I is granted first. After 4 beats there is 1 IDLE cycle, then GrantD with MemReadAddress=DReadAddress.
- Round-robin: I re-requests continuously while D is pending -> grants alternate I, D, I, D. Neither waits more than one burst.
- Late arrival: D requests during beat 2 of an I burst -> I completes all 4 beats uninterrupted, then D is granted. No beat goes to D during the I burst.
- Reset mid-burst: assert reset after beat 2 -> next cycle state IDLE, Grants=0, MemReadRequest=0. A stray MemDataReady produces no xDataReady.
- Spurious beat: MemDataReady=1 in IDLE -> no output beat. The next granted burst still delivers exactly WORDS_PER_BLOCK beats.

Source files
------------

// File: rtl/ucsbece154b_mem_arbiter.sv
// rtl/ucsbece154b_mem_arbiter.sv - two-master round-robin block-burst read arbiter for the SDRAM port
module ucsbece154b_mem_arbiter #(
    parameter int WORDS_PER_BLOCK = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IReadRequest,
    input  logic [ADDR_W-1:0] IReadAddress,
    output logic [DATA_W-1:0] IDataIn,
    output logic              IDataReady,
    input  logic              DReadRequest,
    input  logic [ADDR_W-1:0] DReadAddress,
    output logic [DATA_W-1:0] DDataIn,
    output logic              DDataReady,
    output logic              MemReadRequest,
    output logic [ADDR_W-1:0] MemReadAddress,
    input  logic [DATA_W-1:0] MemDataIn,
    input  logic              MemDataReady,
    output logic              GrantI,
    output logic              GrantD,
    output logic              Busy
);

    localparam int CNT_W = $clog2(WORDS_PER_BLOCK + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             last_grant_q, last_grant_d;   // 1: D was served last
    logic             own_i, own_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                // Beats arriving while idle are ignored and never touch the counter.
                if (IReadRequest && DReadRequest) begin
                    state_d = last_grant_q ? GNT_I : GNT_D;
                end else if (IReadRequest) begin
                    state_d = GNT_I;
                end else if (DReadRequest) begin
                    state_d = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (MemDataReady) begin
                    if (count_q == LAST_BEAT) begin
                        state_d      = IDLE;
                        count_d      = '0;
                        last_grant_d = (state_q == GNT_D);
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Reset masks ownership in the same cycle so in-flight beats are dropped.
    always_comb begin
        own_i          = (state_q == GNT_I) && !reset;
        own_d          = (state_q == GNT_D) && !reset;
        GrantI         = own_i;
        GrantD         = own_d;
        Busy           = own_i || own_d;
        MemReadRequest = own_i || own_d;
        MemReadAddress = '0;
        if (own_i) begin
            MemReadAddress = IReadAddress;
        end else if (own_d) begin
            MemReadAddress = DReadAddress;
        end
        IDataIn    = MemDataIn;
        DDataIn    = MemDataIn;
        IDataReady = own_i && MemDataReady;
        DDataReady = own_d && MemDataReady;
    end

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// tb/tb_ucsbece154b_mem_arbiter.sv - scoreboard bench for the two-master memory arbiter
module tb_ucsbece154b_mem_arbiter;

    localparam int W      = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              IReadRequest, DReadRequest;
    logic [ADDR_W-1:0] IReadAddress, DReadAddress;
    logic [DATA_W-1:0] IDataIn, DDataIn;
    logic              IDataReady, DDataReady;
    logic              MemReadRequest;
    logic [ADDR_W-1:0] MemReadAddress;
    logic [DATA_W-1:0] MemDataIn;
    logic              MemDataReady;
    logic              GrantI, GrantD, Busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W:0] exp_q[$];   // {owner(1=D), data}

    always #5 clk = ~clk;

    ucsbece154b_mem_arbiter #(
        .WORDS_PER_BLOCK(W),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .IReadRequest(IReadRequest),
        .IReadAddress(IReadAddress),
        .IDataIn(IDataIn),
        .IDataReady(IDataReady),
        .DReadRequest(DReadRequest),
        .DReadAddress(DReadAddress),
        .DDataIn(DDataIn),
        .DDataReady(DDataReady),
        .MemReadRequest(MemReadRequest),
        .MemReadAddress(MemReadAddress),
        .MemDataIn(MemDataIn),
        .MemDataReady(MemDataReady),
        .GrantI(GrantI),
        .GrantD(GrantD),
        .Busy(Busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (IDataReady || DDataReady) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", {62'd0, IDataReady, DDataReady}, 64'd0);
            end else begin
                logic [DATA_W:0] e;
                e = exp_q.pop_front();
                check_eq("beat_single_owner", 64'(IDataReady & DDataReady), 64'd0);
                check_eq("beat_owner", 64'(DDataReady), 64'(e[DATA_W]));
                check_eq("beat_data", 64'(DDataReady ? DDataIn : IDataIn), 64'(e[DATA_W-1:0]));
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_grant_i"}, 64'(GrantI), 64'd0);
        check_eq({tag, "_grant_d"}, 64'(GrantD), 64'd0);
        check_eq({tag, "_mem_req"}, 64'(MemReadRequest), 64'd0);
        check_eq({tag, "_mem_addr"}, 64'(MemReadAddress), 64'd0);
        check_eq({tag, "_busy"}, 64'(Busy), 64'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset        = 1'b1;
        IReadRequest = 1'b0;
        DReadRequest = 1'b0;
        MemDataReady = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        check_eq("reset_i_ready", 64'(IDataReady), 64'd0);
        check_eq("reset_d_ready", 64'(DDataReady), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Requester of master m must already be high; grant expected at the second negedge.
    task automatic serve_burst(input bit m, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] base, input bit drop, input int raise_d_at);
        int waited;
        waited = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m ? GrantD : GrantI) begin
                waited = i;
                break;
            end
        end
        check_eq("grant_latency", 64'(waited), 64'd1);
        if (waited < 0) return;
        check_eq("other_grant_low", 64'(m ? GrantI : GrantD), 64'd0);
        check_eq("mem_req_high", 64'(MemReadRequest), 64'd1);
        check_eq("busy_high", 64'(Busy), 64'd1);
        check_eq("mem_addr", 64'(MemReadAddress), 64'(addr));
        for (int b = 0; b < W; b++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 1) == 1) begin
                MemDataReady = 1'b0;
                @(posedge clk); #1;
            end
            check_eq("grant_held", 64'(m ? GrantD : GrantI), 64'd1);
            check_eq("grant_exclusive", 64'(GrantI & GrantD), 64'd0);
            MemDataIn    = base + DATA_W'(b);
            MemDataReady = 1'b1;
            exp_q.push_back({m, base + DATA_W'(b)});
            if (b == raise_d_at) DReadRequest = 1'b1;
        end
        @(posedge clk); #1;
        MemDataReady = 1'b0;
        if (drop) begin
            if (m) DReadRequest = 1'b0;
            else   IReadRequest = 1'b0;
        end
        check_idle_outputs("gap");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        IReadRequest = 1'b0;
        DReadRequest = 1'b0;
        IReadAddress = '0;
        DReadAddress = '0;
        MemDataIn    = '0;
        MemDataReady = 1'b0;
        apply_reset();

        // Solo I
        IReadAddress = 32'h100;
        IReadRequest = 1'b1;
        serve_burst(1'b0, 32'h100, 32'hA0, 1'b1, -1);

        // Tie straight out of reset: I first, then D
        apply_reset();
        IReadAddress = 32'h200;
        DReadAddress = 32'h800;
        IReadRequest = 1'b1;
        DReadRequest = 1'b1;
        serve_burst(1'b0, 32'h200, 32'hB0, 1'b1, -1);
        serve_burst(1'b1, 32'h800, 32'hC0, 1'b1, -1);

        // Round-robin with both held continuously
        IReadAddress = 32'h240;
        DReadAddress = 32'h840;
        IReadRequest = 1'b1;
        DReadRequest = 1'b1;
        serve_burst(1'b0, 32'h240, 32'h1000, 1'b0, -1);
        serve_burst(1'b1, 32'h840, 32'h2000, 1'b0, -1);
        serve_burst(1'b0, 32'h240, 32'h3000, 1'b1, -1);
        serve_burst(1'b1, 32'h840, 32'h4000, 1'b1, -1);

        // Late D arrival during the second beat of an I burst
        IReadAddress = 32'h300;
        DReadAddress = 32'h900;
        IReadRequest = 1'b1;
        serve_burst(1'b0, 32'h300, 32'h5000, 1'b1, 1);
        serve_burst(1'b1, 32'h900, 32'h6000, 1'b1, -1);

        // Reset after two beats of an I burst
        IReadAddress = 32'h400;
        IReadRequest = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_burst_grant", 64'(GrantI), 64'd1);
        for (int b = 0; b < 2; b++) begin
            MemDataIn    = 32'h7000 + DATA_W'(b);
            MemDataReady = 1'b1;
            exp_q.push_back({1'b0, 32'h7000 + DATA_W'(b)});
            @(posedge clk); #1;
        end
        reset        = 1'b1;
        IReadRequest = 1'b0;
        MemDataIn    = 32'hDEAD;
        MemDataReady = 1'b1;
        @(negedge clk);
        check_eq("rst_cycle_i_ready", 64'(IDataReady), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_outputs("post_reset");
        check_eq("post_reset_i_ready", 64'(IDataReady), 64'd0);
        check_eq("post_reset_d_ready", 64'(DDataReady), 64'd0);

        // Spurious beats while idle, then a full burst must still be four beats
        @(posedge clk); #1;
        check_eq("spurious_i_ready", 64'(IDataReady), 64'd0);
        check_eq("spurious_d_ready", 64'(DDataReady), 64'd0);
        MemDataReady = 1'b0;
        DReadAddress = 32'hA00;
        DReadRequest = 1'b1;
        serve_burst(1'b1, 32'hA00, 32'h8000, 1'b1, -1);

        // Tie again: D was last, so I wins
        IReadAddress = 32'h500;
        DReadAddress = 32'hB00;
        IReadRequest = 1'b1;
        DReadRequest = 1'b1;
        serve_burst(1'b0, 32'h500, 32'h9000, 1'b1, -1);
        serve_burst(1'b1, 32'hB00, 32'h9100, 1'b1, -1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
